vram_rect_fill: RTL and testbench

- Upstream VRAM writer: fills an axis-aligned rectangle of the 320x240, 4-bit-per-pixel framebuffer with one colour.
- Drives port A of the dual-port synchronous VRAM. The scan-out path (vga_driver plus VRAM interface) reads port B concurrently.
- Packing: 4 pixels per 16-bit word. Pixel (x,y) lives at word y*80 + x[8:2], nibble x[1:0]; nibble 0 is bits [3:0].
- Partial words use read-modify-write so neighbouring pixels are preserved.

---
 rtl/vram_rect_fill_if.sv | 37 +++
 rtl/vram_rect_fill.sv | 228 ++++++++++++++++++++++
 tb/tb_vram_rect_fill.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_rect_fill_if.sv
// rtl/vram_rect_fill_if.sv - request/status and VRAM port A bundle for vram_rect_fill
//
// Purpose: groups the fill request, its status and the VRAM port A bus.
// Signals:
//   start, x0, y0, x1, y1, colour - fill request (sampled by the engine in IDLE)
//   busy, done                    - engine status
//   address_a, data_in_a, enable_a, rw_a - VRAM port A command from the engine
//   data_out_a                    - VRAM port A read data, valid the cycle after a read
// Modports:
//   master - the fill engine (drives status and port A command)
//   slave  - the environment (drives the request and the VRAM read data)

interface vram_rect_fill_if;
  logic        start;
  logic [8:0]  x0;
  logic [8:0]  y0;
  logic [8:0]  x1;
  logic [8:0]  y1;
  logic [3:0]  colour;
  logic        busy;
  logic        done;
  logic [15:0] address_a;
  logic [15:0] data_in_a;
  logic [15:0] data_out_a;
  logic        enable_a;
  logic        rw_a;

  modport master (
    input  start, x0, y0, x1, y1, colour, data_out_a,
    output busy, done, address_a, data_in_a, enable_a, rw_a
  );

  modport slave (
    output start, x0, y0, x1, y1, colour, data_out_a,
    input  busy, done, address_a, data_in_a, enable_a, rw_a
  );
endinterface

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle fill engine writing VRAM port A
//
// Purpose: fills an axis-aligned rectangle of a 4-bit-per-pixel framebuffer
// with one colour. Four pixels share a 16-bit word (pixel x sits in nibble
// x[1:0] of word y*WORDS_PER_ROW + x/4). Words only partly covered by the
// rectangle are read-modify-written so neighbouring pixels survive.
//
// Ports:
//   clock    - system clock, all logic on the rising edge
//   reset_n  - synchronous active-low reset; abandons a fill in progress
//   bus      - vram_rect_fill_if.master:
//                start/x0/y0/x1/y1/colour request in, busy/done status out,
//                address_a/data_in_a/enable_a/rw_a out, data_out_a in
//
// Build option:
//   VRAM_RECT_FILL_FAST_WORD_EN - words fully inside the rectangle skip the
//   read and merge states and are written directly with the fill colour.

module vram_rect_fill #(
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int WORDS_PER_ROW = SCREEN_W / 4
) (
  input  logic             clock,
  input  logic             reset_n,
  vram_rect_fill_if.master bus
);

  localparam logic [8:0]  X_MAX  = 9'(SCREEN_W - 1);
  localparam logic [8:0]  Y_MAX  = 9'(SCREEN_H - 1);
  localparam logic [15:0] STRIDE = 16'(WORDS_PER_ROW);

`ifdef VRAM_RECT_FILL_FAST_WORD_EN
  localparam bit FAST_WORD = 1'b1;
`else
  localparam bit FAST_WORD = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, RD, MG, WR, DONE} state_t;

  state_t state, state_n;

  // request captured on start
  logic [8:0] req_x0, req_y0, req_x1, req_y1;
  logic [3:0] req_colour;

  // rectangle after clamp and sort, held for the whole fill
  logic [8:0] xa, xb, yb;
  logic [6:0] col_lo, col_hi;

  // current word position
  logic [6:0]  col, col_n;
  logic [8:0]  row, row_n;
  logic [15:0] base, base_n;

  // registered outputs
  logic [15:0] address_q, address_n;
  logic [15:0] data_in_q, data_in_n;
  logic        enable_q, rw_q, busy_q, done_q;

  // clamp/sort of the latched request
  logic [8:0] cx0, cy0, cx1, cy1;
  logic [8:0] s_xa, s_xb, s_ya, s_yb;

  logic [3:0]  mask_cur, mask_next;
  logic [15:0] fill_word, mask16;

  // y * WORDS_PER_ROW as a sum of shifted copies of y (constant shift-add)
  function automatic logic [15:0] row_base(input logic [8:0] y);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (STRIDE[i]) acc = acc + (16'(y) << i);
    end
    return acc;
  endfunction

  // bit n set when pixel 4*c+n lies inside [lo, hi]
  function automatic logic [3:0] nib_mask(input logic [6:0] c,
                                          input logic [8:0] lo,
                                          input logic [8:0] hi);
    logic [3:0] m;
    logic [8:0] px;
    m = 4'h0;
    for (int n = 0; n < 4; n++) begin
      px   = {c, 2'b00} + 9'(n);
      m[n] = (px >= lo) && (px <= hi);
    end
    return m;
  endfunction

  function automatic logic [15:0] expand(input logic [3:0] m);
    logic [15:0] e;
    e = '0;
    for (int n = 0; n < 4; n++) e[4*n +: 4] = {4{m[n]}};
    return e;
  endfunction

  always_comb begin
    cx0  = (req_x0 > X_MAX) ? X_MAX : req_x0;
    cx1  = (req_x1 > X_MAX) ? X_MAX : req_x1;
    cy0  = (req_y0 > Y_MAX) ? Y_MAX : req_y0;
    cy1  = (req_y1 > Y_MAX) ? Y_MAX : req_y1;
    s_xa = (cx0 <= cx1) ? cx0 : cx1;
    s_xb = (cx0 <= cx1) ? cx1 : cx0;
    s_ya = (cy0 <= cy1) ? cy0 : cy1;
    s_yb = (cy0 <= cy1) ? cy1 : cy0;
  end

  // next state, next word position and next registered outputs
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    base_n    = base;
    data_in_n = data_in_q;
    mask_next = 4'h0;
    fill_word = {4{req_colour}};
    mask_cur  = nib_mask(col, xa, xb);
    mask16    = expand(mask_cur);

    case (state)
      IDLE: begin
        if (bus.start) state_n = SETUP;
      end
      SETUP: begin
        col_n     = s_xa[8:2];
        row_n     = s_ya;
        base_n    = row_base(s_ya);
        mask_next = nib_mask(col_n, s_xa, s_xb);
        state_n   = (FAST_WORD && mask_next == 4'hF) ? WR : RD;
      end
      RD: begin
        state_n = MG;
      end
      MG: begin
        data_in_n = (bus.data_out_a & ~mask16) | (fill_word & mask16);
        state_n   = WR;
      end
      WR: begin
        if (col < col_hi) begin
          col_n     = col + 7'd1;
          mask_next = nib_mask(col_n, xa, xb);
          state_n   = (FAST_WORD && mask_next == 4'hF) ? WR : RD;
        end else if (row < yb) begin
          row_n     = row + 9'd1;
          base_n    = base + STRIDE;
          col_n     = col_lo;
          mask_next = nib_mask(col_lo, xa, xb);
          state_n   = (FAST_WORD && mask_next == 4'hF) ? WR : RD;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // a word reaching WR without passing MG is fully covered: plain fill word
    if (state_n == WR && state != MG) data_in_n = fill_word;

    // address follows the word about to be accessed, otherwise holds
    address_n = (state_n == RD || state_n == WR) ? base_n + 16'(col_n) : address_q;
  end

  // outputs are registered from the next state so they line up with the state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_x0     <= '0;
      req_y0     <= '0;
      req_x1     <= '0;
      req_y1     <= '0;
      req_colour <= '0;
      xa         <= '0;
      xb         <= '0;
      yb         <= '0;
      col_lo     <= '0;
      col_hi     <= '0;
      col        <= '0;
      row        <= '0;
      base       <= '0;
      address_q  <= '0;
      data_in_q  <= '0;
      enable_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      base      <= base_n;
      address_q <= address_n;
      data_in_q <= data_in_n;
      enable_q  <= (state_n == RD) || (state_n == WR);
      rw_q      <= (state_n == WR);
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == DONE);
      if (state == IDLE && bus.start) begin
        req_x0     <= bus.x0;
        req_y0     <= bus.y0;
        req_x1     <= bus.x1;
        req_y1     <= bus.y1;
        req_colour <= bus.colour;
      end
      if (state == SETUP) begin
        xa     <= s_xa;
        xb     <= s_xb;
        yb     <= s_yb;
        col_lo <= s_xa[8:2];
        col_hi <= s_xb[8:2];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.enable_a  = enable_q;
  assign bus.rw_a      = rw_q;
  assign bus.address_a = address_q;
  assign bus.data_in_a = data_in_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// tb/tb_vram_rect_fill.sv - self-checking bench for vram_rect_fill

module tb_vram_rect_fill;
  localparam int W      = 320;
  localparam int H      = 240;
  localparam int WPR    = W / 4;
  localparam int NWORDS = WPR * H;
  localparam int BUDGET = 3000;

`ifdef VRAM_RECT_FILL_FAST_WORD_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vram_rect_fill_if bus ();

  vram_rect_fill dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // VRAM port A model with preload hooks
  logic [15:0] mem     [NWORDS];
  logic [15:0] ref_mem [NWORDS];
  int          reads  = 0;
  int          writes = 0;
  int          init_mode = 0;
  logic [15:0] init_val  = '0;
  int          init_idx  = 0;

  always @(posedge clock) begin
    if (init_mode == 1) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_val;
    end else if (init_mode == 2) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= 16'($urandom);
    end else if (init_mode == 3) begin
      mem[init_idx] <= init_val;
    end
    if (bus.enable_a === 1'b1) begin
      if (bus.rw_a === 1'b1) begin
        if (int'(bus.address_a) < NWORDS) mem[bus.address_a] <= bus.data_in_a;
        writes <= writes + 1;
      end else begin
        if (int'(bus.address_a) < NWORDS) bus.data_out_a <= mem[bus.address_a];
        reads <= reads + 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic preload(input int mode, input logic [15:0] val, input int idx);
    init_mode = mode;
    init_val  = val;
    init_idx  = idx;
    @(negedge clock);
    init_mode = 0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = mem[i];
  endtask

  // reference: paint every pixel, then cost each touched word
  task automatic ref_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [3:0] c,
                          output int cyc, output int rd, output int wr);
    int xa, xb, ya, yb, lo, hi;
    if (x0 > W - 1) x0 = W - 1;
    if (x1 > W - 1) x1 = W - 1;
    if (y0 > H - 1) y0 = H - 1;
    if (y1 > H - 1) y1 = H - 1;
    xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        ref_mem[y * WPR + x / 4][(x % 4) * 4 +: 4] = c;
    cyc = 2; rd = 0; wr = 0;
    for (int y = ya; y <= yb; y++)
      for (int w = xa / 4; w <= xb / 4; w++) begin
        lo = (4 * w > xa) ? 4 * w : xa;
        hi = (4 * w + 3 < xb) ? 4 * w + 3 : xb;
        wr++;
        if (FAST && (hi - lo + 1) == 4) cyc += 1;
        else begin cyc += 3; rd++; end
      end
  endtask

  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [3:0] c, input int dup_at,
                          output int busy_cyc, output int done_cnt, output int done_at,
                          output int rd, output int wr, output bit finished);
    int r0, w0, tail;
    @(negedge clock);
    r0 = reads; w0 = writes;
    bus.x0 = 9'(x0); bus.y0 = 9'(y0); bus.x1 = 9'(x1); bus.y1 = 9'(y1);
    bus.colour = c; bus.start = 1'b1;
    busy_cyc = 0; done_cnt = 0; done_at = 0; tail = 0; finished = 1'b0;
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clock);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin done_cnt++; if (done_at == 0) done_at = i; end
      if (busy_cyc > 0 && bus.busy !== 1'b1) tail++;
      bus.start = (dup_at == i) ? 1'b1 : 1'b0;
      if (dup_at == i) begin
        bus.x0 = 9'd0; bus.y0 = 9'd0; bus.x1 = 9'd319; bus.y1 = 9'd239; bus.colour = ~c;
      end
      if (tail == 8) begin finished = 1'b1; break; end
    end
    rd = reads - r0; wr = writes - w0;
  endtask

  task automatic count_diffs(output int n, output int first);
    n = 0; first = -1;
    for (int i = 0; i < NWORDS; i++)
      if (mem[i] !== ref_mem[i]) begin if (n == 0) first = i; n++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.enable_a !== 1'b0 || bus.rw_a !== 1'b0)
      $display("FAIL reset_strobes: got en=%b rw=%b want 0 0", bus.enable_a, bus.rw_a); else n_pass++;
    n_checks++; if (bus.address_a !== 16'h0 || bus.data_in_a !== 16'h0)
      $display("FAIL reset_bus: got addr=%h data=%h want 0 0", bus.address_a, bus.data_in_a); else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_pixel();
    int ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    bit fin;
    preload(1, 16'h0000, 0);
    preload(3, 16'h1234, 161);
    ref_fill(5, 2, 5, 2, 4'hA, ec, er, ew);
    run_fill(5, 2, 5, 2, 4'hA, 0, bc, dc, da, rd, wr, fin);
    count_diffs(nd, fd);
    n_checks++; if (!fin) $display("FAIL single_timeout: busy never cleared"); else n_pass++;
    n_checks++; if (mem[161] !== 16'h12A4) $display("FAIL single_word: got %h want 12a4", mem[161]); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL single_mem: %0d words differ, first %0d", nd, fd); else n_pass++;
    n_checks++; if (wr != 1) $display("FAIL single_writes: got %0d want 1", wr); else n_pass++;
    n_checks++; if (da != 5) $display("FAIL single_done_at: got %0d want 5", da); else n_pass++;
    n_checks++; if (bc != 5) $display("FAIL single_busy: got %0d want 5", bc); else n_pass++;
    n_checks++; if (dc != 1) $display("FAIL single_done_cnt: got %0d want 1", dc); else n_pass++;
  endtask

  task automatic test_full_row();
    int ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    bit fin;
    preload(2, 16'h0000, 0);
    ref_fill(0, 0, 319, 0, 4'hF, ec, er, ew);
    run_fill(0, 0, 319, 0, 4'hF, 0, bc, dc, da, rd, wr, fin);
    count_diffs(nd, fd);
    n_checks++; if (!fin) $display("FAIL row_timeout: busy never cleared"); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL row_mem: %0d words differ, first %0d", nd, fd); else n_pass++;
    n_checks++; if (mem[0] !== 16'hFFFF || mem[79] !== 16'hFFFF)
      $display("FAIL row_ends: got %h %h want ffff ffff", mem[0], mem[79]); else n_pass++;
    n_checks++; if (bc != ec) $display("FAIL row_busy: got %0d want %0d", bc, ec); else n_pass++;
    n_checks++; if (rd != er) $display("FAIL row_reads: got %0d want %0d", rd, er); else n_pass++;
  endtask

  task automatic test_partial_edges();
    int ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    bit fin;
    preload(1, 16'h0000, 0);
    ref_fill(3, 1, 8, 1, 4'h5, ec, er, ew);
    run_fill(3, 1, 8, 1, 4'h5, 0, bc, dc, da, rd, wr, fin);
    count_diffs(nd, fd);
    n_checks++; if (mem[80] !== 16'h5000 || mem[81] !== 16'h5555 || mem[82] !== 16'h0005)
      $display("FAIL edges_words: got %h %h %h want 5000 5555 0005", mem[80], mem[81], mem[82]); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL edges_mem: %0d words differ, first %0d", nd, fd); else n_pass++;
    n_checks++; if (rd != er) $display("FAIL edges_reads: got %0d want %0d", rd, er); else n_pass++;
    n_checks++; if (wr != 3 || bc != ec) $display("FAIL edges_cost: got wr=%0d busy=%0d want 3 %0d", wr, bc, ec); else n_pass++;
  endtask

  task automatic test_swap_clamp();
    int ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    bit fin;
    preload(1, 16'h1111, 0);
    ref_fill(400, 300, 318, 238, 4'h7, ec, er, ew);
    run_fill(400, 300, 318, 238, 4'h7, 0, bc, dc, da, rd, wr, fin);
    count_diffs(nd, fd);
    n_checks++; if (mem[19119] !== 16'h7711 || mem[19199] !== 16'h7711)
      $display("FAIL clamp_words: got %h %h want 7711 7711", mem[19119], mem[19199]); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL clamp_mem: %0d words differ, first %0d", nd, fd); else n_pass++;
    n_checks++; if (wr != 2) $display("FAIL clamp_writes: got %0d want 2", wr); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    bit fin;
    preload(2, 16'h0000, 0);
    ref_fill(10, 20, 25, 22, 4'h3, ec, er, ew);
    run_fill(10, 20, 25, 22, 4'h3, 3, bc, dc, da, rd, wr, fin);
    count_diffs(nd, fd);
    n_checks++; if (dc != 1) $display("FAIL busy_start_done: got %0d want 1", dc); else n_pass++;
    n_checks++; if (nd != 0) $display("FAIL busy_start_mem: %0d words differ, first %0d", nd, fd); else n_pass++;
    n_checks++; if (bc != ec) $display("FAIL busy_start_busy: got %0d want %0d", bc, ec); else n_pass++;
  endtask

  task automatic test_random();
    int x0, y0, x1, y1, ec, er, ew, bc, dc, da, rd, wr, nd, fd;
    logic [3:0] c;
    bit fin;
    for (int k = 0; k < 6; k++) begin
      preload(2, 16'h0000, 0);
      x0 = int'($urandom_range(0, 340));
      y0 = int'($urandom_range(0, 250));
      x1 = x0 + int'($urandom_range(0, 60)) - 30;
      y1 = y0 + int'($urandom_range(0, 8)) - 4;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      c = 4'($urandom);
      ref_fill(x0, y0, x1, y1, c, ec, er, ew);
      run_fill(x0, y0, x1, y1, c, 0, bc, dc, da, rd, wr, fin);
      count_diffs(nd, fd);
      n_checks++; if (nd != 0 || !fin)
        $display("FAIL rand_mem[%0d] (%0d,%0d)-(%0d,%0d): %0d words differ, first %0d, fin=%0d", k, x0, y0, x1, y1, nd, fd, fin); else n_pass++;
      n_checks++; if (bc != ec || dc != 1)
        $display("FAIL rand_timing[%0d]: got busy=%0d done=%0d want %0d 1", k, bc, dc, ec); else n_pass++;
      n_checks++; if (rd != er || wr != ew)
        $display("FAIL rand_access[%0d]: got rd=%0d wr=%0d want %0d %0d", k, rd, wr, er, ew); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fill();
    int k, r0, w0, dc, bz, bad;
    k = FAST ? 4 : 8;
    preload(1, 16'h0000, 0);
    @(negedge clock);
    bus.x0 = 9'd0; bus.y0 = 9'd0; bus.x1 = 9'd319; bus.y1 = 9'd0; bus.colour = 4'hF;
    bus.start = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0 || bus.enable_a !== 1'b0)
      $display("FAIL midreset_outputs: got busy=%b en=%b want 0 0", bus.busy, bus.enable_a); else n_pass++;
    reset_n = 1'b1;
    r0 = reads; w0 = writes; dc = 0; bz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) dc++;
      if (bus.busy === 1'b1) bz++;
    end
    n_checks++; if (dc != 0 || bz != 0) $display("FAIL midreset_idle: got done=%0d busy=%0d want 0 0", dc, bz); else n_pass++;
    n_checks++; if (reads != r0 || writes != w0)
      $display("FAIL midreset_access: got %0d accesses want 0", (reads - r0) + (writes - w0)); else n_pass++;
    bad = 0;
    for (int i = 3; i < NWORDS; i++) if (mem[i] !== 16'h0000) bad++;
    n_checks++; if (mem[0] !== 16'hFFFF || mem[1] !== 16'hFFFF || bad != 0)
      $display("FAIL midreset_mem: got w0=%h w1=%h dirty=%0d want ffff ffff 0", mem[0], mem[1], bad); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.colour = '0;
    test_reset();
    test_single_pixel();
    test_full_row();
    test_partial_edges();
    test_swap_clamp();
    test_start_while_busy();
    test_random();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
